// File: rtl/cmd_initiator.sv
// Command initiator: sends a command letter plus binary argument characters, then collects the reply.
// Optional echo filtering of the responder's echoes is enabled by defining CMD_INITIATOR_ECHO_FILTER_EN.
module cmd_initiator #(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cmdChar,
  input  logic [3:0] argLen,
  input  logic [9:0] argBits,
  input  logic       echoEn,
  input  logic [7:0] rxData,
  input  logic       rxDataWr,
  output logic [7:0] Cmd,
  output logic       NewCmd,
  output logic       busy,
  output logic       done,
  output logic       ackOk,
  output logic       errFlag,
  output logic       timeout,
  output logic [7:0] respChar
);

  localparam int unsigned GAP_W  = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TCNT_W = 24;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TO_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SEND_CMD, GAP, SEND_ARG, WAIT_RESP, FINISH} state_t;

  state_t            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [9:0]        arg_q, arg_d;
  logic [3:0]        left_q, left_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [7:0]        cmd_d, resp_d;
  logic              new_cmd_d, busy_d, done_d, ack_d, err_d, tmo_d;
  logic              rx_live, timer_run, go_fin, is_query, no_reply;
  logic [3:0]        arg_len_c, bit_idx;

`ifdef CMD_INITIATOR_ECHO_FILTER_EN
  logic [3:0] echo_q, echo_d;
`else
  logic unused_echo;
  assign unused_echo = echoEn;
`endif

  assign is_query = (op_q == 8'h41) || (op_q == 8'h46) || (op_q == 8'h4C);
  assign no_reply = (op_q == 8'h72) || (op_q == 8'h52);

  // Next-state and next-output logic; all outputs are registered from the *_d values.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    arg_d     = arg_q;
    left_d    = left_q;
    gap_d     = gap_q;
    tcnt_d    = tcnt_q;
    cmd_d     = Cmd;
    new_cmd_d = 1'b0;
    busy_d    = busy;
    done_d    = 1'b0;
    ack_d     = ackOk;
    err_d     = errFlag;
    tmo_d     = timeout;
    resp_d    = respChar;
    rx_live   = rxDataWr;
    timer_run = 1'b1;
    go_fin    = 1'b0;
    arg_len_c = (argLen > 4'd10) ? 4'd10 : argLen;
    bit_idx   = left_q - 4'd1;
`ifdef CMD_INITIATOR_ECHO_FILTER_EN
    echo_d    = echo_q;
    // Echoes are swallowed in any active state, before any reply is looked at.
    if ((state_q != IDLE) && rxDataWr && (echo_q != 4'd0)) begin
      echo_d  = echo_q - 4'd1;
      rx_live = 1'b0;
    end
    timer_run = (echo_q == 4'd0);
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = cmdChar;
          arg_d     = argBits;
          left_d    = arg_len_c;
          ack_d     = 1'b0;
          err_d     = 1'b0;
          tmo_d     = 1'b0;
          busy_d    = 1'b1;
          cmd_d     = cmdChar;
          new_cmd_d = 1'b1;
          state_d   = SEND_CMD;
`ifdef CMD_INITIATOR_ECHO_FILTER_EN
          echo_d    = echoEn ? (4'd1 + arg_len_c) : 4'd0;
`endif
        end
      end
      SEND_CMD, SEND_ARG: begin
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (left_q != 4'd0) begin
            cmd_d     = arg_q[bit_idx] ? 8'h31 : 8'h30;
            new_cmd_d = 1'b1;
            left_d    = left_q - 4'd1;
            state_d   = SEND_ARG;
          end else if (no_reply) begin
            ack_d  = 1'b1;
            go_fin = 1'b1;
          end else begin
            tcnt_d  = '0;
            state_d = WAIT_RESP;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      WAIT_RESP: begin
        // A reply on the terminal-count cycle wins over the timeout.
        if (rx_live && is_query) begin
          resp_d = rxData - 8'd48;
          ack_d  = 1'b1;
          go_fin = 1'b1;
        end else if (rx_live && (rxData == 8'h2A)) begin
          ack_d  = 1'b1;
          go_fin = 1'b1;
        end else if (rx_live && (rxData == 8'h21)) begin
          err_d  = 1'b1;
          go_fin = 1'b1;
        end else if (timer_run) begin
          if (tcnt_q == TO_LAST) begin
            tmo_d  = 1'b1;
            go_fin = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_fin) begin
      state_d = FINISH;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      arg_q    <= '0;
      left_q   <= '0;
      gap_q    <= '0;
      tcnt_q   <= '0;
      Cmd      <= '0;
      NewCmd   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ackOk    <= 1'b0;
      errFlag  <= 1'b0;
      timeout  <= 1'b0;
      respChar <= '0;
`ifdef CMD_INITIATOR_ECHO_FILTER_EN
      echo_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
      left_q   <= left_d;
      gap_q    <= gap_d;
      tcnt_q   <= tcnt_d;
      Cmd      <= cmd_d;
      NewCmd   <= new_cmd_d;
      busy     <= busy_d;
      done     <= done_d;
      ackOk    <= ack_d;
      errFlag  <= err_d;
      timeout  <= tmo_d;
      respChar <= resp_d;
`ifdef CMD_INITIATOR_ECHO_FILTER_EN
      echo_q   <= echo_d;
`endif
    end
  end

endmodule

// File: tb/tb_cmd_initiator.sv
// Bench for cmd_initiator: directed table, hand-written reset/echo sequences and random
// transactions checked against a timing/outcome model of the command protocol.
module tb_cmd_initiator;

  localparam int GAP = 4;
  localparam int TO  = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cmdChar = '0;
  logic [3:0] argLen = '0;
  logic [9:0] argBits = '0;
  logic       echoEn = 1'b0;
  logic [7:0] rxData = '0;
  logic       rxDataWr = 1'b0;
  logic [7:0] Cmd;
  logic       NewCmd, busy, done, ackOk, errFlag, timeout;
  logic [7:0] respChar;

  cmd_initiator #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmdChar(cmdChar), .argLen(argLen),
    .argBits(argBits), .echoEn(echoEn), .rxData(rxData), .rxDataWr(rxDataWr),
    .Cmd(Cmd), .NewCmd(NewCmd), .busy(busy), .done(done), .ackOk(ackOk),
    .errFlag(errFlag), .timeout(timeout), .respChar(respChar)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] resp_model = '0;

  typedef struct {
    logic [7:0] c;
    logic [3:0] len;
    logic [9:0] bits;
    int         k;      // reply in WAIT_RESP cycle k, -1 = none
    logic [7:0] rc;
    bit         junk;   // stray rx and start while busy
    bit         ack, err, tmo;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit query_cmd(input logic [7:0] c);
    return (c == "A") || (c == "F") || (c == "L");
  endfunction

  function automatic bit noreply_cmd(input logic [7:0] c);
    return (c == "r") || (c == "R");
  endfunction

  function automatic bit interpreted(input logic [7:0] c, input int k, input logic [7:0] rc);
    return !noreply_cmd(c) && (k >= 0) && (k < TO) && (query_cmd(c) || rc == "*" || rc == "!");
  endfunction

  // Runs one transaction from an IDLE negedge; expected timing derived from the protocol rules.
  task automatic run_txn(input string nm, input logic [7:0] c, input logic [3:0] len,
                         input logic [9:0] bits, input int k, input logic [7:0] rc, input bit junk,
                         input bit e_ack, input bit e_err, input bit e_to);
    logic [7:0] exp_c[$];
    int         exp_t[$];
    logic [7:0] obs_c[$];
    int         obs_t[$];
    int eff, w, done_exp, done_obs, ndone, busy_bad, mism, clr_bad;
    eff = (len > 4'd10) ? 10 : int'(len);
    exp_c.push_back(c);
    exp_t.push_back(0);
    for (int i = eff - 1; i >= 0; i--) begin
      exp_c.push_back(bits[i] ? "1" : "0");
      exp_t.push_back((eff - i) * (GAP + 1));
    end
    w = eff * (GAP + 1) + GAP + 1;
    if (noreply_cmd(c)) done_exp = w;
    else if (interpreted(c, k, rc)) done_exp = w + k + 1;
    else done_exp = w + TO;
    if (interpreted(c, k, rc) && query_cmd(c)) resp_model = rc - 8'd48;

    cmdChar = c; argLen = len; argBits = bits; start = 1'b1;
    @(negedge clk);
    done_obs = -1; ndone = 0; busy_bad = 0; clr_bad = 0;
    for (int n = 0; n <= done_exp + 3; n++) begin
      if (NewCmd) begin obs_c.push_back(Cmd); obs_t.push_back(n); end
      if (done) begin ndone++; if (done_obs < 0) done_obs = n; end
      if (busy !== (n < done_exp)) busy_bad++;
      if (n == 0 && (ackOk || errFlag || timeout)) clr_bad++;
      start    = junk && (n == 2);
      cmdChar  = (junk && n == 2) ? "R" : c;
      rxDataWr = (junk && n == 1) || (k >= 0 && n == w + k);
      rxData   = (junk && n == 1) ? "*" : rc;
      @(negedge clk);
    end
    start = 1'b0; rxDataWr = 1'b0;

    check({nm, " nchars"}, obs_c.size(), exp_c.size());
    mism = 0;
    if (obs_c.size() == exp_c.size())
      foreach (obs_c[i]) if (obs_c[i] !== exp_c[i] || obs_t[i] != exp_t[i]) mism++;
    check({nm, " chars"}, mism, 0);
    check({nm, " done_cycle"}, done_obs, done_exp);
    check({nm, " done_count"}, ndone, 1);
    check({nm, " busy"}, busy_bad, 0);
    check({nm, " clear"}, clr_bad, 0);
    check({nm, " flags"}, {ackOk, errFlag, timeout}, {e_ack, e_err, e_to});
    check({nm, " resp"}, respChar, resp_model);
  endtask

  vec_t tbl[13];
  logic [7:0] cpool[8];
  logic [7:0] rpool[4];

  initial begin
    tbl[0]  = '{"T", 4'd0,  10'h000, 5,   "*", 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{"V", 4'd10, 10'h201, 3,   "*", 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{"A", 4'd0,  10'h000, 2,   "7", 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{"C", 4'd0,  10'h000, -1,  "*", 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{"B", 4'd3,  10'h005, 0,   "!", 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{"D", 4'd1,  10'h001, 99,  "*", 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{"E", 4'd1,  10'h001, 100, "*", 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{"r", 4'd2,  10'h002, -1,  "*", 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{"R", 4'd0,  10'h000, -1,  "*", 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{"G", 4'd15, 10'h2C5, 1,   "*", 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{"F", 4'd2,  10'h002, 99,  "3", 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{"H", 4'd0,  10'h000, 4,   "x", 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{"L", 4'd0,  10'h000, 0,   "!", 1'b0, 1'b1, 1'b0, 1'b0};
    cpool = '{"T", "A", "F", "L", "r", "R", "C", "Z"};
    rpool = '{"*", "!", "5", "q"};

    // Reset state, both during and after reset.
    repeat (3) @(negedge clk);
    check("reset_hold", {Cmd, NewCmd, busy, done, ackOk, errFlag, timeout, respChar}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", {Cmd, NewCmd, busy, done, ackOk, errFlag, timeout, respChar}, 0);

`ifdef CMD_INITIATOR_ECHO_FILTER_EN
    begin : echo_seq
      logic [7:0] echoes[9];
      int done_at;
      bit early_err;
      echoes = '{"Y", "1", "1", "!", "1", "1", "1", "1", "1"};
      done_at = -1; early_err = 1'b0;
      echoEn = 1'b1; cmdChar = "Y"; argLen = 4'd8; argBits = 10'h0FF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 60; n++) begin
        if (done && done_at < 0) done_at = n;
        if (n <= 48 && errFlag) early_err = 1'b1;
        rxDataWr = (n >= 1 && n <= 9) || (n == 48);
        rxData   = (n >= 1 && n <= 9) ? echoes[n-1] : "!";
        @(negedge clk);
      end
      rxDataWr = 1'b0; echoEn = 1'b0;
      check("echo early_err", early_err, 0);
      check("echo done_cycle", done_at, 49);
      check("echo flags", {ackOk, errFlag, timeout}, 3'b010);
    end
`endif

    for (int i = 0; i < 13; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].c, tbl[i].len, tbl[i].bits, tbl[i].k, tbl[i].rc,
              tbl[i].junk, tbl[i].ack, tbl[i].err, tbl[i].tmo);

    // Reset in the middle of argument transmission.
    begin : reset_seq
      int late;
      cmdChar = "V"; argLen = 4'd10; argBits = 10'h201; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("rst precond NewCmd", NewCmd, 1);
      rst_n = 1'b0;
      #1;
      check("rst async outputs", {Cmd, NewCmd, busy, done, ackOk, errFlag, timeout, respChar}, 0);
      resp_model = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      late = 0;
      for (int n = 0; n < 60; n++) begin
        if (NewCmd || done || busy) late++;
        @(negedge clk);
      end
      check("rst no_residue", late, 0);
      run_txn("post_reset", "T", 4'd2, 10'h003, 7, "*", 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Random transactions against the protocol model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] c, rc;
      int k, sel;
      bit ea, ee, et;
      c   = cpool[$urandom_range(0, 7)];
      rc  = rpool[$urandom_range(0, 3)];
      sel = $urandom_range(0, 5);
      k   = (sel == 0) ? -1 : (sel == 1) ? 99 : (sel == 2) ? 100 : int'($urandom_range(0, 30));
`ifndef CMD_INITIATOR_ECHO_FILTER_EN
      echoEn = 1'($urandom_range(0, 1));
`endif
      ea = 1'b0; ee = 1'b0; et = 1'b0;
      if (noreply_cmd(c)) ea = 1'b1;
      else if (!interpreted(c, k, rc)) et = 1'b1;
      else if (query_cmd(c) || rc == "*") ea = 1'b1;
      else ee = 1'b1;
      run_txn($sformatf("rnd%0d", i), c, 4'($urandom_range(0, 15)), 10'($urandom), k, rc,
              1'($urandom_range(0, 1)), ea, ee, et);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmd_initiator.md
CMD_INITIATOR -- requirements
Module: cmd_initiator

Interface
REQ-001 Parameter GAP_CYCLES, default 4, idle cycles between successive transmitted characters (legal minimum 2).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, cycles allowed in WAIT_RESP before timeout (24-bit counter).
REQ-003 Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request to issue a command
- cmdChar  in  8  ASCII command letter
- argLen  in  4  number of binary argument characters, 0..10
- argBits  in  10  argument value, sent MSB-first from bit argLen-1
- echoEn  in  1  responder echo is on
- rxData  in  8  response character from responder
- rxDataWr  in  1  rxData valid, one cycle per character
- Cmd  out  8  character to responder
- NewCmd  out  1  Cmd valid, one-cycle pulse
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- ackOk  out  1  last transaction got "*" or needed no reply
- errFlag  out  1  last transaction got "!"
- timeout  out  1  last transaction timed out
- respChar  out  8  last digit reply, converted to 0..9

Function
REQ-004 States: IDLE, SEND_CMD, GAP, SEND_ARG, WAIT_RESP, FINISH.
REQ-005 IDLE: start=1 latches cmdChar, argBits and min(argLen,10); the next state is SEND_CMD; busy=1 from the following cycle.
REQ-006 SEND_CMD: NewCmd=1 and Cmd=cmdChar for exactly one cycle; then GAP.
REQ-007 GAP lasts GAP_CYCLES cycles with NewCmd=0; then SEND_ARG if arguments remain, else WAIT_RESP.
REQ-008 SEND_ARG: one-cycle NewCmd with Cmd="1" or "0" for the current bit, MSB-first; the argument counter decrements; then GAP.
REQ-009 Commands "r" and "R" expect no reply: after the final GAP go to FINISH with ackOk=1.
REQ-010 Commands "A", "F", "L" are queries: the first interpreted character in WAIT_RESP is the reply; respChar = rxData-8'd48 and ackOk=1.
REQ-011 All other commands: "*" gives ackOk=1; "!" gives errFlag=1; both go to FINISH.
REQ-012 In WAIT_RESP, for non-query commands, any other character is ignored and the timeout counter keeps running.
REQ-013 When the WAIT_RESP counter reaches TIMEOUT_CYCLES, set timeout=1 and go to FINISH.
REQ-014 A reply in the same cycle as the timeout terminal count takes priority over the timeout.
REQ-015 FINISH: done=1 for one cycle, busy=0; then IDLE. Status flags hold until the next start.
REQ-016 start while busy=1 is ignored, with no queuing.
REQ-017 start clears ackOk, errFlag and timeout; respChar holds its value.
REQ-018 rxDataWr outside WAIT_RESP is discarded, except as counted by REQ-022.

Reset
REQ-019 rst_n=0 forces IDLE immediately, including mid-transaction.
REQ-020 Reset clears Cmd, NewCmd, busy, done, ackOk, errFlag, timeout, respChar and all counters to 0.
REQ-021 No partial character or done pulse follows reset release.

Configuration
REQ-022 With macro CMD_INITIATOR_ECHO_FILTER_EN defined and echoEn=1, discard exactly 1+argLen received characters (the echoes) from start onward before any reply is interpreted; the timeout counter runs only after the last echo is discarded.
REQ-023 With the macro undefined, echoEn is ignored; there is no echo counter and the first character received in WAIT_RESP is interpreted.

Verification
REQ-024 cmdChar="T", argLen=0, "*" 10 cycles after NewCmd -> one NewCmd of 0x54, done, ackOk=1.
REQ-025 cmdChar="V", argLen=10, argBits=10'b1000000001, GAP_CYCLES=4 -> NewCmd chars "V","1","0"x8,"1" spaced 5 cycles apart; then "*" gives ackOk=1.
REQ-026 cmdChar="A", reply "7" -> respChar=7, ackOk=1.
REQ-027 cmdChar="C", no reply, TIMEOUT_CYCLES=100 -> timeout=1 and done exactly 100 cycles into WAIT_RESP.
REQ-028 Macro defined, echoEn=1, "Y" with argLen=8: echoes "Y", then "1","1","!" -> echoes "Y" and "1" discarded, "1" and "!" still waiting to be discarded, errFlag stays 0 until a real "!" arrives after 9 echoes, then errFlag=1.
REQ-029 rst_n low during SEND_ARG -> no further NewCmd, all outputs 0; a new start afterwards completes normally.
